// File: rtl/pipe_ctrl_unit.sv
// Pipelined MIPS control unit: decode in D, registered control bundles for X/M/W with
// load-use interlock, branch resolution in X and flush. Optional counters: PIPE_CTRL_PERF_CNT_EN.
package mips_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLT, ALU_SLL, ALU_SRL, ALU_SRA, ALU_ABS
  } t_alu_opcode;

  typedef enum logic [4:0] {
    NEM_ZERO, NEM_ADD, NEM_AND, NEM_OR, NEM_SLT, NEM_SUB, NEM_XOR, NEM_SRA, NEM_SRL, NEM_SLL,
    NEM_ADDI, NEM_ADDIU, NEM_BEQ, NEM_BNE, NEM_LW, NEM_SW, NEM_JUMP, NEM_ABS
  } t_instr_pnmen;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ABS   = 6'h01;
  localparam logic [5:0] OP_JUMP  = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_SLT = 6'h2A;

endpackage

module pipe_ctrl_unit
  import mips_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
`ifdef PIPE_CTRL_PERF_CNT_EN
  ,
  parameter int unsigned CNT_W      = 16
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_W-1:0]     instr_D,
  input  logic                  instr_valid_D,
  input  logic                  zero_X,
  output t_alu_opcode           alu_control_X,
  output logic                  reg_dst_X,
  output logic                  alu_src_X,
  output logic                  mem_read_M,
  output logic                  mem_write_M,
  output logic                  mem_to_reg_W,
  output logic                  reg_write_W,
  output logic [REG_ADDR_W-1:0] dest_reg_W,
  output logic                  valid_X,
  output logic                  valid_M,
  output logic                  valid_W,
  output t_instr_pnmen          instr_pnem_X,
  output t_instr_pnmen          instr_pnem_M,
  output t_instr_pnmen          instr_pnem_W,
  output logic                  stall_D,
  output logic                  flush_D,
  output logic                  branch_taken_X,
  output logic                  jump_D,
`ifdef PIPE_CTRL_PERF_CNT_EN
  output logic [CNT_W-1:0]      stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
`endif
  output logic                  illegal_D
);

  typedef struct packed {
    logic                  valid;
    t_alu_opcode           alu;
    logic                  reg_dst;
    logic                  alu_src;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic                  branch_eq;
    logic                  branch_ne;
    logic [REG_ADDR_W-1:0] dest;
    t_instr_pnmen          pnem;
  } ctrl_x_t;

  typedef struct packed {
    logic                  valid;
    logic                  mem_read;
    logic                  mem_write;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] dest;
    t_instr_pnmen          pnem;
  } ctrl_m_t;

  typedef struct packed {
    logic                  valid;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] dest;
    t_instr_pnmen          pnem;
  } ctrl_w_t;

  ctrl_x_t x_q, x_d, dec;
  ctrl_m_t m_q, m_d;
  ctrl_w_t w_q, w_d;

  logic [5:0]            opcode, funct;
  logic [REG_ADDR_W-1:0] rs_d, rt_d, rd_d;
  logic                  legal, is_jump, reads_rt, load_use;

  assign opcode = instr_D[DATA_W-1 -: 6];
  assign funct  = instr_D[5:0];
  assign rs_d   = instr_D[21 +: REG_ADDR_W];
  assign rt_d   = instr_D[16 +: REG_ADDR_W];
  assign rd_d   = instr_D[11 +: REG_ADDR_W];

  always_comb begin
    dec         = '0;
    dec.valid   = 1'b1;
    dec.alu     = ALU_ADD;
    dec.pnem    = NEM_ZERO;
    legal       = 1'b1;
    is_jump     = 1'b0;
    reads_rt    = (opcode == OP_RTYPE) || (opcode == OP_BEQ) || (opcode == OP_BNE) ||
                  (opcode == OP_SW);
    // The all-zero word is a live NOP, not SLL $0,$0,0.
    if (instr_D != '0) begin
      unique case (opcode)
        OP_RTYPE: begin
          dec.reg_dst   = 1'b1;
          dec.reg_write = 1'b1;
          dec.dest      = rd_d;
          unique case (funct)
            FN_ADD:  begin dec.alu = ALU_ADD; dec.pnem = NEM_ADD; end
            FN_SUB:  begin dec.alu = ALU_SUB; dec.pnem = NEM_SUB; end
            FN_AND:  begin dec.alu = ALU_AND; dec.pnem = NEM_AND; end
            FN_OR:   begin dec.alu = ALU_OR;  dec.pnem = NEM_OR;  end
            FN_XOR:  begin dec.alu = ALU_XOR; dec.pnem = NEM_XOR; end
            FN_SLT:  begin dec.alu = ALU_SLT; dec.pnem = NEM_SLT; end
            FN_SLL:  begin dec.alu = ALU_SLL; dec.pnem = NEM_SLL; end
            FN_SRL:  begin dec.alu = ALU_SRL; dec.pnem = NEM_SRL; end
            FN_SRA:  begin dec.alu = ALU_SRA; dec.pnem = NEM_SRA; end
            default: legal = 1'b0;
          endcase
        end
        OP_ADDI, OP_ADDIU: begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.dest      = rt_d;
          dec.pnem      = (opcode == OP_ADDI) ? NEM_ADDI : NEM_ADDIU;
        end
        OP_LW: begin
          dec.alu_src    = 1'b1;
          dec.mem_read   = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.reg_write  = 1'b1;
          dec.dest       = rt_d;
          dec.pnem       = NEM_LW;
        end
        OP_SW: begin
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          dec.pnem      = NEM_SW;
        end
        OP_BEQ: begin
          dec.alu       = ALU_SUB;
          dec.branch_eq = 1'b1;
          dec.pnem      = NEM_BEQ;
        end
        OP_BNE: begin
          dec.alu       = ALU_SUB;
          dec.branch_ne = 1'b1;
          dec.pnem      = NEM_BNE;
        end
        OP_JUMP: begin
          is_jump  = 1'b1;
          dec.pnem = NEM_JUMP;
        end
        OP_ABS: begin
          dec.alu       = ALU_ABS;
          dec.reg_write = 1'b1;
          dec.dest      = rt_d;
          dec.pnem      = NEM_ABS;
        end
        default: legal = 1'b0;
      endcase
    end
    if (dec.dest == '0) dec.reg_write = 1'b0;
  end

  // Hazard, redirect and illegal outputs are held low while reset is asserted.
  always_comb begin
    load_use = x_q.valid && x_q.mem_read && (x_q.dest != '0) && instr_valid_D &&
               ((x_q.dest == rs_d) || ((x_q.dest == rt_d) && reads_rt));
    branch_taken_X = rst && x_q.valid &&
                     ((x_q.branch_eq && zero_X) || (x_q.branch_ne && !zero_X));
    flush_D   = branch_taken_X;
    stall_D   = rst && !flush_D && load_use;
    jump_D    = rst && is_jump && legal && instr_valid_D && !flush_D && !stall_D;
    illegal_D = rst && instr_valid_D && !legal;
  end

  always_comb begin
    x_d = '0;
    if (instr_valid_D && legal && !flush_D && !stall_D) x_d = dec;

    m_d            = '0;
    m_d.valid      = x_q.valid;
    m_d.mem_read   = x_q.mem_read;
    m_d.mem_write  = x_q.mem_write;
    m_d.mem_to_reg = x_q.mem_to_reg;
    m_d.reg_write  = x_q.reg_write;
    m_d.dest       = x_q.dest;
    m_d.pnem       = x_q.pnem;

    w_d            = '0;
    w_d.valid      = m_q.valid;
    w_d.mem_to_reg = m_q.mem_to_reg;
    w_d.reg_write  = m_q.reg_write;
    w_d.dest       = m_q.dest;
    w_d.pnem       = m_q.pnem;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      x_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      x_q <= x_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

  assign alu_control_X = x_q.alu;
  assign reg_dst_X     = x_q.reg_dst;
  assign alu_src_X     = x_q.alu_src;
  assign valid_X       = x_q.valid;
  assign instr_pnem_X  = x_q.pnem;
  assign mem_read_M    = m_q.mem_read;
  assign mem_write_M   = m_q.mem_write;
  assign valid_M       = m_q.valid;
  assign instr_pnem_M  = m_q.pnem;
  assign mem_to_reg_W  = w_q.mem_to_reg;
  assign reg_write_W   = w_q.reg_write;
  assign dest_reg_W    = w_q.dest;
  assign valid_W       = w_q.valid;
  assign instr_pnem_W  = w_q.pnem;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall_D && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush_D && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: doc/pipe_ctrl_unit.md
Name: pipe_ctrl_unit

Overview:
- Next-generation MIPS control unit. Decodes the instruction in Decode (D) and owns the registered control bundle for the Execute (X), Memory (M) and Writeback (W) stages.
- Adds valid bits, destination-register tracking, load-use interlock, branch resolution in X (BEQ and BNE), and flush/bubble insertion.
- Sits between the IF/ID register and the datapath. The datapath consumes only the staged control outputs.

Parameters:
- DATA_W, 32, instruction width.
- REG_ADDR_W, 5, register-index width.
- CNT_W, 16, width of the performance counters (optional feature only).

Ports:
- clk  in  1  clock
- rst  in  1  reset
- instr_D  in  DATA_W  instruction in D
- instr_valid_D  in  1  instr_D holds a real instruction
- zero_X  in  1  ALU zero flag for the instruction in X
- alu_control_X  out  t_alu_opcode  ALU operation
- reg_dst_X  out  1  select rd as destination
- alu_src_X  out  1  select immediate operand
- mem_read_M  out  1  data-memory read
- mem_write_M  out  1  data-memory write
- mem_to_reg_W  out  1  writeback from memory
- reg_write_W  out  1  register-file write enable
- dest_reg_W  out  REG_ADDR_W  register-file write index
- valid_X / valid_M / valid_W  out  1 each  stage holds a live instruction
- instr_pnem_X / instr_pnem_M / instr_pnem_W  out  t_instr_pnmen  stage mnemonic, for debug
- stall_D  out  1  hold PC and IF/ID this cycle
- flush_D  out  1  squash IF/ID contents
- branch_taken_X  out  1  redirect PC to the branch target
- jump_D  out  1  redirect PC to the jump target
- illegal_D  out  1  unsupported opcode/funct in D
- stall_cnt / flush_cnt  out  CNT_W each  present only with the optional feature

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-low.
- At the first clk edge with rst=0, every stage register clears:
  - valid=0, all control bits 0, alu_control ALU_ADD, pnem NEM_ZERO, dest 0, counters 0.
  - stall_D, flush_D, branch_taken_X, jump_D and illegal_D evaluate to 0 because all valids are 0.
  - A reset asserted mid-pipeline discards all in-flight instructions. No partial state survives.
- Decode is combinational on instr_D. Supported set:
  - R-type functs: ADD, AND, OR, SLT, SUB, XOR, SRA, SRL, SLL.
  - Opcodes: ADDI, ADDIU, BEQ, BNE, LW, SW, JUMP, ABS.
  - BNE is opcode 6'h05 with mnemonic NEM_BNE, both added to mips_pkg.
  - Control values for the pre-existing instructions are unchanged.
  - BNE: ALU_SUB, Branch set, no register write.
- All-zero instr_D is a NOP: live slot, reg_write 0, pnem NEM_ZERO. SLL with a nonzero word is a real shift.
- Unknown opcode or funct while instr_valid_D=1:
  - illegal_D=1.
  - The slot enters X as a bubble (valid 0).
- Destination register:
  - R-type: rd.
  - ADDI, ADDIU, LW, ABS: rt.
  - All others: 0.
  - reg_write is forced to 0 when dest=0.
- Stage advance: D→X→M→W, one stage per cycle. Latency is D+1 to X, D+2 to M, D+3 to W. M and W always advance.
- Load-use interlock (stall_D) is 1 when all of the following hold:
  - valid_X, mem_read_X and dest_X != 0.
  - instr_valid_D.
  - dest_X == rs_D, or (dest_X == rt_D and the D instruction reads rt). R-type, BEQ, BNE and SW read rt.
- Stall response: X loads a bubble. D is held by upstream. Stall lasts exactly 1 cycle per hazard.
- Branch: branch_taken_X = valid_X & ((BEQ_X & zero_X) | (BNE_X & !zero_X)).
  - When taken: flush_D=1 and the D instruction enters X as a bubble.
  - Flush has priority over stall (stall_D=0) and over jump (jump_D=0).
- Jump: jump_D = JUMP decoded & instr_valid_D & !flush_D & !stall_D.
  - The jump enters X as a valid, non-writing slot.
- Bubble: valid=0 with every control bit 0. Downstream enables are always gated by valid.
- Simultaneous events in one cycle: reset > flush > stall > normal advance.

Optional Feature:
- Macro: PIPE_CTRL_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with stall_D=1.
  - flush_cnt increments on every cycle with flush_D=1.
  - Both saturate at all-ones and clear on reset.
- Undefined: both ports and registers are absent. All other behaviour is identical.

Test Plan:
- Reset: rst=0 for 2 cycles with arbitrary instr_D → all valid_*=0, reg_write_W=0, mem_write_M=0, pnem NEM_ZERO, counters 0.
- ADD $3,$1,$2 at D cycle t → at t+3: reg_write_W=1, dest_reg_W=3, mem_to_reg_W=0, pnem_W=NEM_ADD.
- LW $4,0($1) followed by ADD $5,$4,$2 → stall_D=1 for exactly 1 cycle, valid_X=0 that cycle, ADD reaches W 4 cycles after entering D; stall_cnt=1.
- BNE in X with zero_X=0 → branch_taken_X=1, flush_D=1, next valid_X=0. Same with zero_X=1 → no flush. BEQ mirrored.
- Branch taken in X while D holds a load-use consumer → flush_D=1, stall_D=0, flush_cnt=1.
- Opcode 6'h3F with instr_valid_D=1 → illegal_D=1, next valid_X=0. Word 32'h0 → valid_X=1, reg_write 0, pnem NEM_ZERO.
